// File: rtl/sap1_pkg.sv
// Shared SAP-1 definitions: control-word bit positions, opcodes, widths,
// memory-stage FSM states and the demo program used when SAP_MEM_INIT_EN is defined.
package sap1_pkg;

    localparam int DEF_ADDR_W = 4;
    localparam int DEF_DATA_W = 8;

    // Control word bit indices, MSB first
    localparam int CW_HLT       = 11;
    localparam int CW_PC_INC    = 10;
    localparam int CW_PC_EN     = 9;
    localparam int CW_MEM_LOAD  = 8;
    localparam int CW_MEM_EN    = 7;
    localparam int CW_IR_LOAD   = 6;
    localparam int CW_IR_EN     = 5;
    localparam int CW_A_LOAD    = 4;
    localparam int CW_A_EN      = 3;
    localparam int CW_B_LOAD    = 2;
    localparam int CW_ADDER_SUB = 1;
    localparam int CW_ADDER_EN  = 0;

    localparam logic [3:0] OP_LDA = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_HLT = 4'hF;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_PROG,
        ST_WAIT,
        ST_SYNC
    } mem_state_t;

    // LDA 9; ADD A; SUB B; HLT; data words at 9..B
    localparam logic [7:0] DEMO_PROG [0:15] = '{
        8'h09, 8'h1A, 8'h2B, 8'hF0, 8'h00, 8'h00, 8'h00, 8'h00,
        8'h00, 8'h10, 8'h14, 8'h18, 8'h00, 8'h00, 8'h00, 8'h00
    };

endpackage

// File: rtl/sap_memory_unit_if.sv
// Host programming handshake for the SAP-1 memory stage.
interface sap_memory_unit_if #(
    parameter int ADDR_W = sap1_pkg::DEF_ADDR_W,
    parameter int DATA_W = sap1_pkg::DEF_DATA_W
);
    logic              prog_mode;
    logic              prog_valid;
    logic              prog_ready;
    logic [ADDR_W-1:0] prog_addr;
    logic [DATA_W-1:0] prog_data;

    modport master (
        output prog_mode, prog_valid, prog_addr, prog_data,
        input  prog_ready
    );

    modport slave (
        input  prog_mode, prog_valid, prog_addr, prog_data,
        output prog_ready
    );
endinterface

// File: rtl/sap_ram16x8.sv
// SAP-1 program/data RAM: synchronous write, combinational read, reset-time init.
// Define SAP_MEM_INIT_EN to reset to the demo program instead of all zeros.
module sap_ram16x8
    import sap1_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);
    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_words [DEPTH];

    // Each word is its own register so reset can load a per-address constant
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_word
`ifdef SAP_MEM_INIT_EN
        localparam logic [DATA_W-1:0] INIT_WORD = DATA_W'(DEMO_PROG[gi]);
`else
        localparam logic [DATA_W-1:0] INIT_WORD = '0;
`endif
        logic [DATA_W-1:0] word_reg;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                word_reg <= INIT_WORD;
            end else if (we && (waddr == ADDR_W'(gi))) begin
                word_reg <= wdata;
            end
        end

        assign mem_words[gi] = word_reg;
    end

    assign rdata = mem_words[raddr];

endmodule

// File: rtl/sap_memory_unit.sv
// SAP-1 memory stage: MAR + 16x8 RAM with a host programming port that holds the CPU.
// Define SAP_MEM_INIT_EN to reset the RAM to the demo program.
module sap_memory_unit
    import sap1_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [DATA_W-1:0]  bus_in,
    input  logic               mem_load,
    input  logic               mem_en,
    sap_memory_unit_if.slave   prog,
    output logic               cpu_hold,
    output logic [DATA_W-1:0]  bus_out,
    output logic               bus_drive,
    output logic [ADDR_W-1:0]  mar_q,
    output logic [ADDR_W:0]    prog_count
);
    localparam logic [ADDR_W:0] COUNT_MAX = {1'b1, {ADDR_W{1'b0}}};

    mem_state_t        state_reg;
    logic [ADDR_W-1:0] mar_reg;
    logic [ADDR_W:0]   count_reg;
    logic              hold_reg;
    logic              ram_we;
    logic [DATA_W-1:0] ram_rdata;
    logic              unused_bus_hi;

    assign unused_bus_hi = &{1'b0, bus_in[DATA_W-1:ADDR_W]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_RUN;
            mar_reg   <= '0;
            count_reg <= '0;
            hold_reg  <= 1'b0;
        end else begin
            case (state_reg)
                ST_RUN: begin
                    if (mem_load) mar_reg <= bus_in[ADDR_W-1:0];
                    if (prog.prog_mode) begin
                        state_reg <= ST_PROG;
                        count_reg <= '0;
                        hold_reg  <= 1'b1;
                    end
                end
                ST_PROG: begin
                    if (prog.prog_valid && (count_reg != COUNT_MAX))
                        count_reg <= count_reg + (ADDR_W+1)'(1);
                    // A write arriving with the mode drop is still taken
                    if (!prog.prog_mode)       state_reg <= ST_SYNC;
                    else if (prog.prog_valid)  state_reg <= ST_WAIT;
                end
                ST_WAIT: begin
                    state_reg <= prog.prog_mode ? ST_PROG : ST_SYNC;
                end
                ST_SYNC: begin
                    mar_reg   <= '0;
                    state_reg <= ST_RUN;
                    hold_reg  <= 1'b0;
                end
                default: state_reg <= ST_RUN;
            endcase
        end
    end

    assign ram_we          = (state_reg == ST_PROG) && prog.prog_valid;
    assign prog.prog_ready = (state_reg == ST_PROG);

    sap_ram16x8 #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (ram_we),
        .waddr (prog.prog_addr),
        .wdata (prog.prog_data),
        .raddr (mar_reg),
        .rdata (ram_rdata)
    );

    // Zero-latency read: the controller loads IR/A/B in the same state as MEM_EN
    assign bus_drive  = (state_reg == ST_RUN) && mem_en;
    assign bus_out    = bus_drive ? ram_rdata : '0;
    assign cpu_hold   = hold_reg;
    assign mar_q      = mar_reg;
    assign prog_count = count_reg;

endmodule

// File: tb/tb_sap_memory_unit.sv
// Directed bench for the SAP-1 memory stage; expectations follow SAP_MEM_INIT_EN.
module tb_sap_memory_unit;

    logic       clk;
    logic       rst_n;
    logic [7:0] bus_in;
    logic       mem_load;
    logic       mem_en;
    logic       cpu_hold;
    logic [7:0] bus_out;
    logic       bus_drive;
    logic [3:0] mar_q;
    logic [4:0] prog_count;

    int checks = 0;
    int errors = 0;
    logic [7:0] ram_model [16];

    sap_memory_unit_if pif ();

    sap_memory_unit dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus_in     (bus_in),
        .mem_load   (mem_load),
        .mem_en     (mem_en),
        .prog       (pif),
        .cpu_hold   (cpu_hold),
        .bus_out    (bus_out),
        .bus_drive  (bus_drive),
        .mar_q      (mar_q),
        .prog_count (prog_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] init_word(input int a);
`ifdef SAP_MEM_INIT_EN
        case (a)
            0:  return 8'h09;
            1:  return 8'h1A;
            2:  return 8'h2B;
            3:  return 8'hF0;
            9:  return 8'h10;
            10: return 8'h14;
            11: return 8'h18;
            default: return 8'h00;
        endcase
`else
        return 8'h00;
`endif
    endfunction

    task automatic model_reset;
        for (int i = 0; i < 16; i++) ram_model[i] = init_word(i);
    endtask

    task automatic set_mar(input logic [7:0] value);
        @(negedge clk);
        mem_load = 1'b1;
        bus_in   = value;
        @(negedge clk);
        mem_load = 1'b0;
        bus_in   = 8'h00;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #2;
        checks++; if (cpu_hold !== 1'b0) begin errors++; $display("FAIL rst_hold: got %b exp 0", cpu_hold); end
        checks++; if (pif.prog_ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b exp 0", pif.prog_ready); end
        checks++; if (bus_drive !== 1'b0) begin errors++; $display("FAIL rst_drive: got %b exp 0", bus_drive); end
        checks++; if (bus_out !== 8'h00) begin errors++; $display("FAIL rst_bus: got %h exp 00", bus_out); end
        checks++; if (mar_q !== 4'h0) begin errors++; $display("FAIL rst_mar: got %h exp 0", mar_q); end
        checks++; if (prog_count !== 5'd0) begin errors++; $display("FAIL rst_count: got %0d exp 0", prog_count); end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        $display("reset released");
    endtask

    task automatic test_read_init;
        @(negedge clk);
        mem_en = 1'b1;
        #1;
        checks++; if (bus_drive !== 1'b1) begin errors++; $display("FAIL rd0_drive: got %b exp 1", bus_drive); end
        checks++; if (bus_out !== ram_model[0]) begin errors++; $display("FAIL rd0_data: got %h exp %h", bus_out, ram_model[0]); end
        mem_en = 1'b0;
        set_mar(8'hF9);
        #1;
        checks++; if (mar_q !== 4'h9) begin errors++; $display("FAIL mar_load: got %h exp 9", mar_q); end
        mem_en = 1'b1;
        #1;
        checks++; if (bus_out !== ram_model[9]) begin errors++; $display("FAIL rd9_data: got %h exp %h", bus_out, ram_model[9]); end
        $display("read addr 9 -> %h", bus_out);
        mem_en = 1'b0;
    endtask

    task automatic test_prog_single;
        @(negedge clk);
        pif.prog_mode = 1'b1;
        @(negedge clk);
        #1;
        checks++; if (cpu_hold !== 1'b1) begin errors++; $display("FAIL prog_hold: got %b exp 1", cpu_hold); end
        checks++; if (pif.prog_ready !== 1'b1) begin errors++; $display("FAIL prog_ready: got %b exp 1", pif.prog_ready); end
        checks++; if (prog_count !== 5'd0) begin errors++; $display("FAIL prog_count0: got %0d exp 0", prog_count); end
        mem_en = 1'b1;
        #1;
        checks++; if (bus_drive !== 1'b0) begin errors++; $display("FAIL prog_drive: got %b exp 0", bus_drive); end
        checks++; if (bus_out !== 8'h00) begin errors++; $display("FAIL prog_bus: got %h exp 00", bus_out); end
        mem_en = 1'b0;
        pif.prog_valid = 1'b1;
        pif.prog_addr  = 4'h3;
        pif.prog_data  = 8'hE5;
        ram_model[3]   = 8'hE5;
        $display("write addr 3 data e5");
        @(negedge clk);
        #1;
        checks++; if (pif.prog_ready !== 1'b0) begin errors++; $display("FAIL wait_ready: got %b exp 0", pif.prog_ready); end
        checks++; if (prog_count !== 5'd1) begin errors++; $display("FAIL prog_count1: got %0d exp 1", prog_count); end
        @(negedge clk);
        #1;
        checks++; if (pif.prog_ready !== 1'b1) begin errors++; $display("FAIL ready_back: got %b exp 1", pif.prog_ready); end
        pif.prog_valid = 1'b0;
        pif.prog_mode  = 1'b0;
        @(negedge clk);
        #1;
        checks++; if (cpu_hold !== 1'b1) begin errors++; $display("FAIL sync_hold: got %b exp 1", cpu_hold); end
        checks++; if (pif.prog_ready !== 1'b0) begin errors++; $display("FAIL sync_ready: got %b exp 0", pif.prog_ready); end
        @(negedge clk);
        #1;
        checks++; if (cpu_hold !== 1'b0) begin errors++; $display("FAIL run_hold: got %b exp 0", cpu_hold); end
        checks++; if (mar_q !== 4'h0) begin errors++; $display("FAIL sync_mar: got %h exp 0", mar_q); end
        checks++; if (prog_count !== 5'd1) begin errors++; $display("FAIL keep_count: got %0d exp 1", prog_count); end
        set_mar(8'h03);
        mem_en = 1'b1;
        #1;
        checks++; if (bus_out !== 8'hE5) begin errors++; $display("FAIL rd3_prog: got %h exp e5", bus_out); end
        mem_en = 1'b0;
    endtask

    task automatic test_back_to_back;
        @(negedge clk);
        pif.prog_mode = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 18; i++) begin
            pif.prog_valid = 1'b1;
            pif.prog_addr  = 4'(i);
            pif.prog_data  = 8'h40 + 8'(i);
            ram_model[i % 16] = 8'h40 + 8'(i);
            $display("write addr %h data %h", pif.prog_addr, pif.prog_data);
            @(negedge clk);
            pif.prog_valid = 1'b0;
            #1;
            checks++; if (pif.prog_ready !== 1'b0) begin errors++; $display("FAIL b2b_wait%0d: got %b exp 0", i, pif.prog_ready); end
            if (i < 16) begin
                checks++; if (prog_count !== 5'(i + 1)) begin errors++; $display("FAIL b2b_count%0d: got %0d exp %0d", i, prog_count, i + 1); end
            end
            @(negedge clk);
        end
        #1;
        checks++; if (prog_count !== 5'd16) begin errors++; $display("FAIL count_sat: got %0d exp 16", prog_count); end
        pif.prog_mode = 1'b0;
        @(negedge clk);
        @(negedge clk);
        for (int a = 0; a < 16; a++) begin
            set_mar(8'(a));
            mem_en = 1'b1;
            #1;
            checks++; if (bus_out !== ram_model[a]) begin errors++; $display("FAIL rdback%0d: got %h exp %h", a, bus_out, ram_model[a]); end
            $display("read addr %h -> %h", a, bus_out);
            mem_en = 1'b0;
        end
    endtask

    task automatic test_load_and_read;
        set_mar(8'h02);
        mem_load = 1'b1;
        mem_en   = 1'b1;
        bus_in   = 8'h07;
        #1;
        checks++; if (bus_out !== ram_model[2]) begin errors++; $display("FAIL ldrd_data: got %h exp %h", bus_out, ram_model[2]); end
        checks++; if (mar_q !== 4'h2) begin errors++; $display("FAIL ldrd_old_mar: got %h exp 2", mar_q); end
        @(negedge clk);
        mem_load = 1'b0;
        mem_en   = 1'b0;
        bus_in   = 8'h00;
        #1;
        checks++; if (mar_q !== 4'h7) begin errors++; $display("FAIL ldrd_new_mar: got %h exp 7", mar_q); end
        $display("load+read: mar now %h", mar_q);
    endtask

    task automatic test_run_ignore;
        @(negedge clk);
        pif.prog_valid = 1'b1;
        pif.prog_addr  = 4'h5;
        pif.prog_data  = 8'hFF;
        #1;
        checks++; if (pif.prog_ready !== 1'b0) begin errors++; $display("FAIL run_ready: got %b exp 0", pif.prog_ready); end
        @(negedge clk);
        @(negedge clk);
        pif.prog_valid = 1'b0;
        set_mar(8'h05);
        mem_en = 1'b1;
        #1;
        checks++; if (bus_out !== ram_model[5]) begin errors++; $display("FAIL run_nowrite: got %h exp %h", bus_out, ram_model[5]); end
        mem_en = 1'b0;
        $display("run-mode write ignored, addr 5 = %h", bus_out);
    endtask

    task automatic test_reset_mid_wait;
        @(negedge clk);
        pif.prog_mode = 1'b1;
        @(negedge clk);
        pif.prog_valid = 1'b1;
        pif.prog_addr  = 4'hA;
        pif.prog_data  = 8'h77;
        @(negedge clk);
        pif.prog_valid = 1'b0;
        #1;
        checks++; if (pif.prog_ready !== 1'b0) begin errors++; $display("FAIL pre_rst_wait: got %b exp 0", pif.prog_ready); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (cpu_hold !== 1'b0) begin errors++; $display("FAIL arst_hold: got %b exp 0", cpu_hold); end
        checks++; if (pif.prog_ready !== 1'b0) begin errors++; $display("FAIL arst_ready: got %b exp 0", pif.prog_ready); end
        checks++; if (mar_q !== 4'h0) begin errors++; $display("FAIL arst_mar: got %h exp 0", mar_q); end
        checks++; if (prog_count !== 5'd0) begin errors++; $display("FAIL arst_count: got %0d exp 0", prog_count); end
        pif.prog_mode = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        mem_en = 1'b1;
        #1;
        checks++; if (bus_out !== ram_model[0]) begin errors++; $display("FAIL reinit0: got %h exp %h", bus_out, ram_model[0]); end
        mem_en = 1'b0;
        set_mar(8'h0A);
        mem_en = 1'b1;
        #1;
        checks++; if (bus_out !== ram_model[10]) begin errors++; $display("FAIL reinitA: got %h exp %h", bus_out, ram_model[10]); end
        mem_en = 1'b0;
        $display("mid-wait reset: addr A = %h", bus_out);
    endtask

    initial begin
        rst_n          = 1'b0;
        bus_in         = 8'h00;
        mem_load       = 1'b0;
        mem_en         = 1'b0;
        pif.prog_mode  = 1'b0;
        pif.prog_valid = 1'b0;
        pif.prog_addr  = 4'h0;
        pif.prog_data  = 8'h00;
        test_reset();
        test_read_init();
        test_prog_single();
        test_back_to_back();
        test_load_and_read();
        test_run_ignore();
        test_reset_mid_wait();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/sap_memory_unit.md
Name: sap_memory_unit

Overview:
- Memory stage of the SAP-1 datapath: 4-bit memory address register (MAR) plus 16x8 RAM.
- Consumes MEM_LOAD and MEM_EN from the controller's control word. Drives RAM data onto the shared 8-bit bus.
- Adds a valid/ready programming port, so a host can write a program while the CPU is held.
- Sits directly downstream of the controller, between the bus and the instruction/A/B registers.

Parameters:
- ADDR_W, 4, MAR/RAM address width (depth = 2**ADDR_W)
- DATA_W, 8, bus and RAM word width

Ports:
- clk  in  1  system clock; all state changes on the rising edge
- rst_n  in  1  asynchronous active-low reset
- bus_in  in  DATA_W  shared bus value; MAR captures bits [ADDR_W-1:0]
- mem_load  in  1  control word bit 8: load MAR from bus
- mem_en  in  1  control word bit 7: drive RAM[MAR] onto bus
- prog_mode  in  1  host request to enter programming mode
- prog_valid  in  1  host write request valid
- prog_addr  in  ADDR_W  host write address
- prog_data  in  DATA_W  host write data
- prog_ready  out  1  block can accept a host write
- cpu_hold  out  1  high while not in RUN; holds controller stage counter and PC
- bus_out  out  DATA_W  RAM[MAR] when bus_drive, else 0
- bus_drive  out  1  block is driving the bus
- mar_q  out  ADDR_W  current MAR value, for debug/LEDs
- prog_count  out  ADDR_W+1  writes accepted this programming session, saturating at 16

Behaviour:
- Reset (async, rst_n=0):
  - state=RUN, MAR=0, prog_count=0, prog_ready=0, cpu_hold=0, bus_drive=0, bus_out=0.
  - RAM contents: see Optional Feature.
- FSM states: RUN, PROG, WAIT, SYNC.
  - RUN -> PROG when prog_mode=1 is sampled. prog_count clears on entry.
  - PROG: prog_ready=1 (combinational from state). prog_valid&prog_ready at an edge writes RAM[prog_addr]=prog_data and moves to WAIT.
  - WAIT: one cycle, prog_ready=0, then back to PROG.
  - PROG -> SYNC when prog_mode=0. A valid in that same cycle is still accepted.
  - WAIT with prog_mode=0 -> SYNC.
  - SYNC: one cycle; MAR cleared to 0, then RUN.
  - cpu_hold=1 in PROG, WAIT and SYNC.
- RUN datapath:
  - Read is combinational: bus_drive=mem_en, bus_out=RAM[MAR] in the same cycle as mem_en. Zero read latency is required because the controller asserts MEM_EN with IR_LOAD/A_LOAD/B_LOAD in one state.
  - mem_load: MAR <= bus_in[ADDR_W-1:0] at the edge; upper bus bits are ignored.
  - mem_load and mem_en together: bus_out shows the old MAR's data; MAR updates at the edge.
- In PROG/WAIT/SYNC, mem_load and mem_en are ignored; bus_drive=0.
- prog_count increments per accepted write and saturates at 16. Rewriting the same address still counts.
- prog_valid while in RUN is ignored; no write occurs.
- Reset mid-session: the FSM returns to RUN immediately; an in-flight write is not guaranteed.

Optional Feature:
- Macro SAP_MEM_INIT_EN.
- Defined: reset loads the demo program. Addresses 0..3 = 8'h09, 8'h1A, 8'h2B, 8'hF0. Addresses 9,A,B = 8'h10, 8'h14, 8'h18. All other addresses = 0.
- Undefined: reset clears all RAM words to 0.

Decomposition:
- Shared package sap1_pkg holds:
  - control-word bit indices (HLT..ADDER_EN, 11..0)
  - opcode constants
  - ADDR_W/DATA_W defaults
  - FSM state enum
  - demo-program constant array used under SAP_MEM_INIT_EN
- One sub-module sap_ram16x8: storage array, synchronous write port, combinational read port, reset init.

Test Plan:
- Reset with SAP_MEM_INIT_EN defined; then mem_en=1, MAR=0 -> bus_out=8'h09, bus_drive=1. Set MAR=9 via bus_in=8'hF9 with mem_load -> mar_q=9, next mem_en gives 8'h10.
- prog_mode=1; write addr 3 = 8'hE5 with valid held high -> prog_ready low for exactly one cycle after acceptance, prog_count=1, cpu_hold=1. Drop prog_mode -> one SYNC cycle, then cpu_hold=0, mar_q=0.
- 18 back-to-back writes in PROG -> prog_count saturates at 16. A read of each address in RUN returns the last data written.
- mem_load=1 and mem_en=1 with MAR=2, bus_in=8'h07 -> bus_out=RAM[2] that cycle, mar_q=7 next cycle.
- prog_valid=1 in RUN -> no RAM change, prog_ready=0. mem_en in PROG -> bus_drive=0.
- rst_n pulsed low mid-WAIT (async, between edges) -> outputs at reset values immediately, state RUN, RAM reinitialised.
